// File: rtl/transpose_stream_ctrl_if.sv
// Streaming handshake shared by the transpose controller, its input/output FIFOs and the transpose core.
interface transpose_stream_ctrl_if;
  logic in_empty;
  logic in_re;
  logic out_almost_full;
  logic out_we;
  logic core_clk_en;
  logic core_start;
  logic core_valid;

  modport master (
    input  in_empty, out_almost_full, core_valid,
    output in_re, out_we, core_clk_en, core_start
  );

  modport slave (
    output in_empty, out_almost_full, core_valid,
    input  in_re, out_we, core_clk_en, core_start
  );
endinterface

// File: rtl/transpose_stream_ctrl.sv
// Job controller that streams cache lines from an input FIFO through a clock-enabled transpose core
// into an output FIFO, then drains the core pipeline with a bounded timeout.
module transpose_stream_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int DRAIN_MAX = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    abort,
  input  logic [CNT_WIDTH-1:0]    ctx_length,
  transpose_stream_ctrl_if.master strm,
  output logic                    busy,
  output logic                    done,
  output logic                    drain_err,
  output logic [CNT_WIDTH-1:0]    in_count,
  output logic [CNT_WIDTH-1:0]    out_count
);

  localparam int                   DRAIN_W    = $clog2(DRAIN_MAX + 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] len;
  logic                 rd_vld;
  logic [DRAIN_W-1:0]   drain_cnt;

  logic kill;
  logic job_start;
  logic in_room;
  logic out_room;
  logic out_last;
  logic in_re;
  logic out_we;
  logic clk_en;
  logic core_start;
  logic drain_tick;
  logic drain_timeout;

  // A reset arriving mid-job silences the FIFO and core strobes exactly like an abort does.
  assign kill      = abort | reset;
  assign job_start = (state == IDLE) & go & ~abort;
  assign in_room   = in_count < len;
  assign out_room  = out_count < len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    in_re         = 1'b0;
    out_we        = 1'b0;
    clk_en        = 1'b0;
    core_start    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    drain_tick    = 1'b0;
    drain_timeout = 1'b0;
    out_last      = ~out_room;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nxt = (ctx_length != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy       = 1'b1;
        core_start = rd_vld;
        in_re      = ~kill & ~strm.in_empty & ~strm.out_almost_full & in_room;
        clk_en     = ~kill & rd_vld;
        out_we     = strm.core_valid & clk_en & out_room;
        out_last   = ~out_room | (out_we & ((out_count + ONE) == len));
        if (~in_room & rd_vld) begin
          state_nxt = out_last ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // No new lines arrive here, so the core free-runs whenever the output FIFO can take data.
        busy       = 1'b1;
        clk_en     = ~kill & ~strm.out_almost_full;
        out_we     = strm.core_valid & clk_en & out_room;
        out_last   = ~out_room | (out_we & ((out_count + ONE) == len));
        drain_tick = clk_en;
        if (out_last) begin
          state_nxt = DONE;
        end else if (drain_tick && (drain_cnt == DRAIN_LAST)) begin
          drain_timeout = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      in_count  <= '0;
      out_count <= '0;
      rd_vld    <= 1'b0;
      drain_cnt <= '0;
      drain_err <= 1'b0;
    end else begin
      rd_vld <= in_re;
      if (job_start) begin
        len       <= ctx_length;
        in_count  <= '0;
        out_count <= '0;
        drain_cnt <= '0;
        drain_err <= 1'b0;
      end else begin
        if (in_re) begin
          in_count <= in_count + ONE;
        end
        if (out_we) begin
          out_count <= out_count + ONE;
        end
        if (drain_tick) begin
          drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
        if (drain_timeout) begin
          drain_err <= 1'b1;
        end
      end
    end
  end

  assign strm.in_re       = in_re;
  assign strm.out_we      = out_we;
  assign strm.core_clk_en = clk_en;
  assign strm.core_start  = core_start;

endmodule
